spi_tx_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single SPI master TX stream (into tx_fifo) among NUM_REQ requesters.

---
 rtl/spi_arb_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/spi_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_spi_tx_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI TX stream arbiter.
// Optional build macro used by the top: SPI_ARB_TIMEOUT_EN.
package spi_arb_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_e;

  // Index -> one-hot over the maximum requester count.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // One-hot -> index (highest set bit wins if more than one is set).
  function automatic logic [IDX_W-1:0] index(input logic [MAX_REQ-1:0] oh);
    index = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) index = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping from NUM_REQ-1 back to 0.
module rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               any_o
);

  int unsigned cand;

  // Scan NUM_REQ candidates starting at the pointer; first hit wins.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    cand  = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr_i) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any_o && req_i[cand[PTR_W-1:0]]) begin
        any_o = 1'b1;
        idx_o = cand[PTR_W-1:0];
      end
    end
    gnt_o = any_o ? NUM_REQ'(onehot(IDX_W'(idx_o))) : '0;
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing the SPI master TX stream among NUM_REQ
// requesters. The grant is locked for a whole burst (until a handshake with
// last). Define SPI_ARB_TIMEOUT_EN to add a stall counter that forces release
// of a requester that stops handshaking for 2^TIMEOUT_W-1 busy cycles.
module spi_tx_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_vld_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_rdy_o,
  output logic [DATA_W-1:0]         stream_data_o,
  output logic                      stream_data_vld_o,
  input  logic                      stream_data_rdy_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      timeout_o
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_W < 2) begin : g_cfg_err
    $error("spi_tx_arbiter: unsupported NUM_REQ/TIMEOUT_W");
  end

  arb_state_e          state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [PTR_W-1:0]    gidx_q;
  logic [PTR_W-1:0]    ptr_q;
  logic                timeout_q;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [PTR_W-1:0]    arb_idx;
  logic                arb_any;
  logic [PTR_W-1:0]    ptr_next;
  logic                busy;
  logic                hs;
  logic                burst_end;
  logic                expire;
  logic                release_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req_i (req_vld_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign busy      = (state_q == BUSY);
  assign hs        = stream_data_vld_o & stream_data_rdy_i;
  assign burst_end = hs & req_last_i[gidx_q];
  assign ptr_next  = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
  assign release_d = burst_end | expire;
  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

  // Passthrough from the granted requester; everything quiet while idle.
  // Valid depends only on the requester, never on the FIFO ready.
  always_comb begin
    stream_data_o     = '0;
    stream_data_vld_o = 1'b0;
    req_rdy_o         = '0;
    if (busy) begin
      stream_data_o     = req_data_i[32'(gidx_q)*DATA_W +: DATA_W];
      stream_data_vld_o = req_vld_i[gidx_q];
      req_rdy_o         = grant_q & {NUM_REQ{stream_data_rdy_i}};
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] stall_q;

  // Busy cycles without a handshake; cleared while idle and on each handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (!busy || hs) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign expire = busy & ~hs & ((stall_q + 1'b1) == '1);
`else
  assign expire = 1'b0;
`endif

  // Arbitration FSM: grant from IDLE, hold through the burst, release to IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            grant_q <= arb_gnt;
            gidx_q  <= arb_idx;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (release_d) begin
            grant_q   <= '0;
            ptr_q     <= ptr_next;
            timeout_q <= expire;
            state_q   <= IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed, table-driven bench for spi_tx_arbiter (NUM_REQ=4, TIMEOUT_W=4).
module tb_spi_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_vld;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_rdy;
  logic [DW-1:0]    s_data;
  logic             s_vld;
  logic             s_rdy;
  logic [NR-1:0]    grant;
  logic             timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_tx_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .TIMEOUT_W (4)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .req_data_i        (req_data),
    .req_vld_i         (req_vld),
    .req_last_i        (req_last),
    .req_rdy_o         (req_rdy),
    .stream_data_o     (s_data),
    .stream_data_vld_o (s_vld),
    .stream_data_rdy_i (s_rdy),
    .grant_o           (grant),
    .timeout_o         (timeout)
  );

  typedef struct {
    logic [NR-1:0] vld;
    logic [NR-1:0] last;
    logic          rdy;
    logic [31:0]   base;
    logic [NR-1:0] e_gnt;
    logic          e_vld;
    logic [NR-1:0] e_rdy;
    logic [31:0]   e_data;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Requester r presents word base + r.
  task automatic set_data(input logic [31:0] base);
    for (int r = 0; r < NR; r++) req_data[r*DW +: DW] = base + 32'(r);
  endtask

  task automatic add(input logic [3:0] vld, input logic [3:0] last, input logic rdy,
                     input logic [31:0] base, input logic [3:0] e_gnt, input logic e_vld,
                     input logic [3:0] e_rdy, input logic [31:0] e_data);
    vec_t v;
    v.vld = vld; v.last = last; v.rdy = rdy; v.base = base;
    v.e_gnt = e_gnt; v.e_vld = e_vld; v.e_rdy = e_rdy; v.e_data = e_data;
    tbl.push_back(v);
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_gnt, input logic e_vld,
                           input logic [3:0] e_rdy, input logic [31:0] e_data, input logic e_to);
    check({tag, " grant"},   32'(grant),   32'(e_gnt));
    check({tag, " vld"},     32'(s_vld),   32'(e_vld));
    check({tag, " rdy"},     32'(req_rdy), 32'(e_rdy));
    check({tag, " data"},    s_data,       e_data);
    check({tag, " timeout"}, 32'(timeout), 32'(e_to));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // 1: idle after reset with no requests
    add(4'b0000, 4'b0000, 1'b1, 32'h0,   4'b0000, 1'b0, 4'b0000, 32'h0);
    add(4'b0000, 4'b0000, 1'b1, 32'h0,   4'b0000, 1'b0, 4'b0000, 32'h0);
    add(4'b0000, 4'b0000, 1'b1, 32'h0,   4'b0000, 1'b0, 4'b0000, 32'h0);
    // 2: all request single-word bursts; rotation with one idle cycle between
    add(4'b1111, 4'b1111, 1'b1, 32'h100, 4'b0000, 1'b0, 4'b0000, 32'h0);
    add(4'b1111, 4'b1111, 1'b1, 32'h100, 4'b0001, 1'b1, 4'b0001, 32'h100);
    add(4'b1111, 4'b1111, 1'b1, 32'h100, 4'b0000, 1'b0, 4'b0000, 32'h0);
    add(4'b1111, 4'b1111, 1'b1, 32'h100, 4'b0010, 1'b1, 4'b0010, 32'h101);
    add(4'b1111, 4'b1111, 1'b1, 32'h100, 4'b0000, 1'b0, 4'b0000, 32'h0);
    add(4'b1111, 4'b1111, 1'b1, 32'h100, 4'b0100, 1'b1, 4'b0100, 32'h102);
    add(4'b1111, 4'b1111, 1'b1, 32'h100, 4'b0000, 1'b0, 4'b0000, 32'h0);
    add(4'b1111, 4'b1111, 1'b1, 32'h100, 4'b1000, 1'b1, 4'b1000, 32'h103);
    add(4'b1111, 4'b1111, 1'b1, 32'h100, 4'b0000, 1'b0, 4'b0000, 32'h0);
    add(4'b1111, 4'b1111, 1'b1, 32'h100, 4'b0001, 1'b1, 4'b0001, 32'h100);
    // 3: req1 three-word burst while req2 waits (pointer now 1)
    add(4'b0110, 4'b0100, 1'b1, 32'h200, 4'b0000, 1'b0, 4'b0000, 32'h0);
    add(4'b0110, 4'b0100, 1'b1, 32'h210, 4'b0010, 1'b1, 4'b0010, 32'h211);
    add(4'b0110, 4'b0100, 1'b1, 32'h220, 4'b0010, 1'b1, 4'b0010, 32'h221);
    add(4'b0110, 4'b0110, 1'b1, 32'h230, 4'b0010, 1'b1, 4'b0010, 32'h231);
    add(4'b0100, 4'b0100, 1'b1, 32'h240, 4'b0000, 1'b0, 4'b0000, 32'h0);
    add(4'b0100, 4'b0100, 1'b1, 32'h250, 4'b0100, 1'b1, 4'b0100, 32'h252);
    add(4'b0000, 4'b0000, 1'b1, 32'h0,   4'b0000, 1'b0, 4'b0000, 32'h0);
    // 4: req3 two words; vld gap, then 5 cycles of FIFO backpressure with noise on req0/req1
    add(4'b1000, 4'b0000, 1'b1, 32'h300, 4'b0000, 1'b0, 4'b0000, 32'h0);
    add(4'b1000, 4'b0000, 1'b1, 32'h310, 4'b1000, 1'b1, 4'b1000, 32'h313);
    add(4'b0000, 4'b0000, 1'b1, 32'h320, 4'b1000, 1'b0, 4'b1000, 32'h323);
    add(4'b1001, 4'b1000, 1'b0, 32'h330, 4'b1000, 1'b1, 4'b0000, 32'h333);
    add(4'b1011, 4'b1000, 1'b0, 32'h330, 4'b1000, 1'b1, 4'b0000, 32'h333);
    add(4'b1001, 4'b1000, 1'b0, 32'h330, 4'b1000, 1'b1, 4'b0000, 32'h333);
    add(4'b1000, 4'b1000, 1'b0, 32'h330, 4'b1000, 1'b1, 4'b0000, 32'h333);
    add(4'b1011, 4'b1000, 1'b0, 32'h330, 4'b1000, 1'b1, 4'b0000, 32'h333);
    add(4'b1000, 4'b1000, 1'b1, 32'h330, 4'b1000, 1'b1, 4'b1000, 32'h333);
    add(4'b0000, 4'b0000, 1'b1, 32'h0,   4'b0000, 1'b0, 4'b0000, 32'h0);

    rst = 1'b1; req_vld = '0; req_last = '0; s_rdy = 1'b0; set_data(32'h0);
    repeat (3) @(negedge clk);
    #1;
    check_all("reset", 4'b0000, 1'b0, 4'b0000, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      req_vld = tbl[i].vld; req_last = tbl[i].last; s_rdy = tbl[i].rdy;
      set_data(tbl[i].base);
      #1;
      check_all($sformatf("row%0d", i), tbl[i].e_gnt, tbl[i].e_vld, tbl[i].e_rdy,
                tbl[i].e_data, 1'b0);
    end

    // 5: move pointer to 2, then reset during word 2 of a 4-word burst from req2
    @(negedge clk); req_vld = 4'b0010; req_last = 4'b0010; s_rdy = 1'b1; set_data(32'h400);
    @(negedge clk); #1;
    check("rst_pre grant1", 32'(grant), 32'(4'b0010));
    @(negedge clk); req_vld = 4'b0100; req_last = 4'b0000; set_data(32'h410);
    @(negedge clk); #1;
    check_all("rst_w1", 4'b0100, 1'b1, 4'b0100, 32'h412, 1'b0);
    @(negedge clk); set_data(32'h420); #1;
    check("rst_w2 grant", 32'(grant), 32'(4'b0100));
    rst = 1'b1; #1;
    check_all("rst_async", 4'b0000, 1'b0, 4'b0000, 32'h0, 1'b0);
    @(negedge clk); rst = 1'b0; req_vld = 4'b1111; req_last = 4'b1111; #1;
    check("rst_idle grant", 32'(grant), 32'(4'b0000));
    @(negedge clk); #1;
    check_all("rst_ptr0", 4'b0001, 1'b1, 4'b0001, 32'h420, 1'b0);
    @(negedge clk); req_vld = '0; req_last = '0; #1;
    check("rst_release grant", 32'(grant), 32'(4'b0000));

    // 6: req1 granted then goes silent while req2 waits (pointer now 1)
    @(negedge clk); req_vld = 4'b0010; req_last = 4'b0000; set_data(32'h500);
    @(negedge clk); req_vld = 4'b0100; #1;
    check_all("to_start", 4'b0010, 1'b0, 4'b0010, 32'h501, 1'b0);
    n = 0;
    while (grant == 4'b0010 && n < 40) begin
      if (timeout !== 1'b0) begin
        errors++; checks++;
        $display("FAIL to_early: got timeout %b expected 0", timeout);
      end
      n++;
      @(negedge clk); #1;
    end
`ifdef SPI_ARB_TIMEOUT_EN
    check("to_busy_cycles", 32'(n), 32'd15);
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_idle grant", 32'(grant), 32'(4'b0000));
    @(negedge clk); #1;
    check("to_pulse_end", 32'(timeout), 32'd0);
    check("to_next grant", 32'(grant), 32'(4'b0100));
`else
    check("hold_busy_cycles", 32'(n), 32'd40);
    check("hold_timeout", 32'(timeout), 32'd0);
    check("hold_grant", 32'(grant), 32'(4'b0010));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
